// File: rtl/north_axi_pkg.sv
// Shared AXI write-address constants and FSM state type
// for the north GDMA write path.
package north_axi_pkg;

  localparam int ADDR_W       = 49;
  localparam int BEAT_BYTES   = 4;
  localparam int WORDS_PER_4K = 1024;
  localparam int WADDR_W      = ADDR_W - $clog2(BEAT_BYTES);
  localparam int CNT_W        = 31;

  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_ISSUE
  } waddr_state_e;

endpackage

// File: rtl/north_waddr.sv
// AXI write-address generator: splits an N-beat transfer
// into INCR bursts that never cross a 4 KB boundary.
module north_waddr
  import north_axi_pkg::*;
#(
  parameter int MAX_BURST = 256
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic [31:0]       length,
  input  logic              op_start,
  output logic              gdma_addr_done,
  output logic [ADDR_W-1:0] gdma_ddr_awaddr,
  output logic [7:0]        gdma_ddr_awlen,
  output logic [2:0]        gdma_ddr_awsize,
  output logic [1:0]        gdma_ddr_awburst,
  output logic              gdma_ddr_awvalid,
  input  logic              gdma_ddr_awready
);

  waddr_state_e       state_q;
  logic [WADDR_W-1:0] word_q;
  logic [CNT_W-1:0]   rem_q;
  logic               done_q;
  logic               awvalid_q;
  logic [ADDR_W-1:0]  awaddr_q;
  logic [7:0]         awlen_q;

  logic [10:0]        room;
  logic [CNT_W-1:0]   room_w;
  logic [CNT_W-1:0]   max_w;
  logic [CNT_W-1:0]   beats;

  // Low address/length bits are beat-aligned and unused.
  logic unused_bits;
  assign unused_bits = ^{start_addr[1:0], length[1:0]};

  // Words left before the next 4 KB page boundary (1..1024).
  assign room   = 11'(WORDS_PER_4K) - {1'b0, word_q[9:0]};
  assign room_w = CNT_W'(room);
  assign max_w  = CNT_W'(MAX_BURST);

  // Burst size is the smallest of cap, page room and remainder.
  always_comb begin
    beats = rem_q;
    if (room_w < beats) beats = room_w;
    if (max_w < beats) beats = max_w;
  end

  // Burst sequencing FSM with registered AW outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      word_q    <= '0;
      rem_q     <= '0;
      done_q    <= 1'b1;
      awvalid_q <= 1'b0;
      awaddr_q  <= '0;
      awlen_q   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (op_start) begin
            word_q  <= start_addr[ADDR_W-1:2];
            rem_q   <= {1'b0, length[31:2]} + 31'd1;
            done_q  <= 1'b0;
            state_q <= ST_CALC;
          end
        end
        ST_CALC: begin
          awaddr_q  <= {word_q, 2'b00};
          awlen_q   <= 8'(beats - 31'd1);
          awvalid_q <= 1'b1;
          state_q   <= ST_ISSUE;
        end
        ST_ISSUE: begin
          if (gdma_ddr_awready) begin
            awvalid_q <= 1'b0;
            word_q    <= word_q + WADDR_W'(beats);
            rem_q     <= rem_q - beats;
            if (rem_q == beats) begin
              done_q  <= 1'b1;
              state_q <= ST_IDLE;
            end else begin
              state_q <= ST_CALC;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign gdma_addr_done   = done_q;
  assign gdma_ddr_awaddr  = awaddr_q;
  assign gdma_ddr_awlen   = awlen_q;
  assign gdma_ddr_awsize  = AXI_SIZE_4B;
  assign gdma_ddr_awburst = AXI_BURST_INCR;
  assign gdma_ddr_awvalid = awvalid_q;

endmodule
